ccsds_turbo_dec_lextr: RTL and testbench

- Stage directly downstream of the a-posteriori LLR unit in the component MAP decoder.
- Aligns per-bit side info (systematic LLR, a-priori LLR, address, framing, previous hard decision) with the Lapo stream. The Lapo unit has a fixed 6-enabled-cycle latency.
- Computes extrinsic LLR = scale(Lapo − Lsys − Lapr) with saturation, and derives the hard decision.
- Counts hard-decision changes per block for early-stop logic.

---
 rtl/ccsds_turbo_dec_lextr.sv | 173 +++++++++++++++++
 tb/tb_ccsds_turbo_dec_lextr.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ccsds_turbo_dec_lextr.sv
// Extrinsic LLR stage behind the a-posteriori LLR unit of the component MAP decoder.
// Delays per-bit side info to meet the Lapo stream, forms the saturated (optionally
// scaled) extrinsic LLR and hard decision, and counts hard-decision changes per block.
module ccsds_turbo_dec_lextr #(
    parameter int pLLR_W    = 5,
    parameter int pLLR_FP   = 3,
    parameter int pMET_W    = 10,
    parameter int pLEXTR_W  = 7,
    parameter int pLAPO_LAT = 6,
    parameter int pSCALE    = 0,
    parameter int pCNT_W    = 16
) (
    input  logic                iclk,
    input  logic                ireset_n,
    input  logic                iclkena,
    input  logic                isval,
    input  logic [pLLR_W-1:0]   iLsys,
    input  logic [pLEXTR_W-1:0] iLapr,
    input  logic                ihd_prev,
    input  logic [15:0]         iaddr,
    input  logic                isop,
    input  logic                ieop,
    input  logic                iLapo_val,
    input  logic [pMET_W-1:0]   iLapo,
    output logic                oval,
    output logic [pLEXTR_W-1:0] oLextr,
    output logic                ohd,
    output logic [15:0]         oaddr,
    output logic                osop,
    output logic                oeop,
    output logic                ochg_val,
    output logic [pCNT_W-1:0]   ochg_cnt,
    output logic                oerr
);

    localparam int DW = pMET_W + 2;
    localparam logic signed [DW-1:0] SAT_P = DW'(2**(pLEXTR_W-1) - 1);
    localparam logic signed [DW-1:0] SAT_N = -SAT_P;

    // All LLR inputs share one fixed-point format, so no rescaling is done here.
    if (pLLR_FP >= pLLR_W) begin : g_fp_range_err
        $error("pLLR_FP must be smaller than pLLR_W");
    end

    typedef struct packed {
        logic                val;
        logic [pLLR_W-1:0]   lsys;
        logic [pLEXTR_W-1:0] lapr;
        logic                hdp;
        logic [15:0]         addr;
        logic                sop;
        logic                eop;
    } side_t;

    side_t side_in, side_out;
    side_t dl_q [pLAPO_LAT];

    logic                 beat;
    logic signed [DW-1:0] lapo_x, lsys_x, lapr_x;
    logic signed [DW-1:0] s1_d_d, s1_d_q;
    logic                 s1_hd_d, s1_hd_q;
    logic                 s1_val_q, s1_hdp_q, s1_sop_q, s1_eop_q;
    logic [15:0]          s1_addr_q;
    logic signed [DW-1:0] sc, sat;
    logic [pLEXTR_W-1:0]  lextr_d;
    logic                 chg;
    logic [pCNT_W-1:0]    cnt_d, cnt_q;
    logic                 err_q;

    // Pack side info and pick the delay-line tap that lines up with the Lapo output.
    always_comb begin
        side_in      = '0;
        side_in.val  = isval;
        side_in.lsys = iLsys;
        side_in.lapr = iLapr;
        side_in.hdp  = ihd_prev;
        side_in.addr = iaddr;
        side_in.sop  = isop;
        side_in.eop  = ieop;
        side_out     = dl_q[pLAPO_LAT-1];
        // A beat is processed if either side claims it, so a lost Lapo valid still yields output.
        beat         = iLapo_val | side_out.val;
    end

    // Side-info delay line: shifts on every enabled cycle, valid or not.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            for (int unsigned i = 0; i < pLAPO_LAT; i++) dl_q[i] <= '0;
        end else if (iclkena) begin
            dl_q[0] <= side_in;
            for (int unsigned i = 1; i < pLAPO_LAT; i++) dl_q[i] <= dl_q[i-1];
        end
    end

    // Stage 1 arithmetic: full-width difference and sign-based hard decision.
    always_comb begin
        lapo_x  = {{(DW-pMET_W){iLapo[pMET_W-1]}}, iLapo};
        lsys_x  = {{(DW-pLLR_W){side_out.lsys[pLLR_W-1]}}, side_out.lsys};
        lapr_x  = {{(DW-pLEXTR_W){side_out.lapr[pLEXTR_W-1]}}, side_out.lapr};
        s1_d_d  = lapo_x - lsys_x - lapr_x;
        s1_hd_d = ~iLapo[pMET_W-1] & (|iLapo);
    end

    // Stage 1 registers, plus the sticky alignment error.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            s1_val_q  <= 1'b0;
            s1_d_q    <= '0;
            s1_hd_q   <= 1'b0;
            s1_hdp_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_sop_q  <= 1'b0;
            s1_eop_q  <= 1'b0;
            err_q     <= 1'b0;
        end else if (iclkena) begin
            s1_val_q <= beat;
            if (beat) begin
                s1_d_q    <= s1_d_d;
                s1_hd_q   <= s1_hd_d;
                s1_hdp_q  <= side_out.hdp;
                s1_addr_q <= side_out.addr;
                s1_sop_q  <= side_out.sop;
                s1_eop_q  <= side_out.eop;
            end
            if (side_out.val != iLapo_val) err_q <= 1'b1;
        end
    end

    // Stage 2 arithmetic: optional x0.75 scaling, symmetric saturation, change counting.
    always_comb begin
        sc = s1_d_q;
        if (pSCALE == 1) sc = s1_d_q - (s1_d_q >>> 2);
        if (sc > SAT_P)      sat = SAT_P;
        else if (sc < SAT_N) sat = SAT_N;
        else                 sat = sc;
        lextr_d = sat[pLEXTR_W-1:0];

        chg = s1_hd_q ^ s1_hdp_q;
        if (s1_sop_q)    cnt_d = pCNT_W'(chg);
        else if (&cnt_q) cnt_d = cnt_q;
        else             cnt_d = cnt_q + pCNT_W'(chg);
    end

    // Stage 2 / output registers; data outputs hold while no beat is presented.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            oval     <= 1'b0;
            oLextr   <= '0;
            ohd      <= 1'b0;
            oaddr    <= '0;
            osop     <= 1'b0;
            oeop     <= 1'b0;
            cnt_q    <= '0;
            ochg_val <= 1'b0;
            ochg_cnt <= '0;
        end else if (iclkena) begin
            oval     <= s1_val_q;
            ochg_val <= s1_val_q & s1_eop_q;
            if (s1_val_q) begin
                oLextr <= lextr_d;
                ohd    <= s1_hd_q;
                oaddr  <= s1_addr_q;
                osop   <= s1_sop_q;
                oeop   <= s1_eop_q;
                cnt_q  <= cnt_d;
                if (s1_eop_q) ochg_cnt <= cnt_d;
            end
        end
    end

    assign oerr = err_q;

endmodule

// File: tb/tb_ccsds_turbo_dec_lextr.sv
// Scoreboard bench for ccsds_turbo_dec_lextr: two instances (no scaling / x0.75)
// share stimulus; expected beats are queued at drive time and popped by a monitor.
module tb_ccsds_turbo_dec_lextr;

    localparam int LAT = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, isval, ihdp, isop, ieop, lapo_val;
    logic [4:0]  lsys;
    logic [6:0]  lapr;
    logic [15:0] iaddr;
    logic [9:0]  lapo;

    logic        oval0, ohd0, osop0, oeop0, chgv0, oerr0;
    logic [6:0]  lextr0;
    logic [15:0] oaddr0, chgc0;
    logic        oval1, ohd1, osop1, oeop1, chgv1, oerr1;
    logic [6:0]  lextr1;
    logic [15:0] oaddr1, chgc1;

    ccsds_turbo_dec_lextr #(.pSCALE(0)) u_dut0 (
        .iclk(clk), .ireset_n(rst_n), .iclkena(en), .isval(isval), .iLsys(lsys),
        .iLapr(lapr), .ihd_prev(ihdp), .iaddr(iaddr), .isop(isop), .ieop(ieop),
        .iLapo_val(lapo_val), .iLapo(lapo), .oval(oval0), .oLextr(lextr0), .ohd(ohd0),
        .oaddr(oaddr0), .osop(osop0), .oeop(oeop0), .ochg_val(chgv0), .ochg_cnt(chgc0),
        .oerr(oerr0)
    );

    ccsds_turbo_dec_lextr #(.pSCALE(1)) u_dut1 (
        .iclk(clk), .ireset_n(rst_n), .iclkena(en), .isval(isval), .iLsys(lsys),
        .iLapr(lapr), .ihd_prev(ihdp), .iaddr(iaddr), .isop(isop), .ieop(ieop),
        .iLapo_val(lapo_val), .iLapo(lapo), .oval(oval1), .oLextr(lextr1), .ohd(ohd1),
        .oaddr(oaddr1), .osop(osop1), .oeop(oeop1), .ochg_val(chgv1), .ochg_cnt(chgc1),
        .oerr(oerr1)
    );

    typedef struct {
        int lapo; int lsys; int lapr;
        bit hdp;  bit sop;  bit eop;
        int e0;   int e1;   bit hd;  int cnt;
    } beat_t;

    typedef struct {
        int e0; int e1; bit hd; int addr;
        bit sop; bit eop; int cnt; int stamp;
    } exp_t;

    beat_t sched[$];
    exp_t  exp_q[$];
    exp_t  me;
    int    checks   = 0;
    int    failures = 0;
    int    abase    = 16;
    int    ecnt     = 0;
    logic  en_q;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push_beat(input int lapo_v, input int lsys_v, input int lapr_v,
                             input bit hdp_v, input bit sop_v, input bit eop_v,
                             input int e0_v, input int e1_v, input bit hd_v, input int cnt_v);
        beat_t b;
        b.lapo = lapo_v; b.lsys = lsys_v; b.lapr = lapr_v;
        b.hdp = hdp_v; b.sop = sop_v; b.eop = eop_v;
        b.e0 = e0_v; b.e1 = e1_v; b.hd = hd_v; b.cnt = cnt_v;
        sched.push_back(b);
    endtask

    // 8-bit block: 3 positions where hd differs from hd_prev (beats 1, 5, 7).
    task automatic load_a();
        //        Lapo  Lsys Lapr hdp sop eop  e0   e1  hd cnt
        push_beat(  40,   5,   3, 0,  1,  0,  32,  24, 1, 0);
        push_beat(   0,   0,   0, 0,  0,  0,   0,   0, 0, 0);
        push_beat( 300, -10,   0, 1,  0,  0,  63,  63, 1, 0);
        push_beat(-300,  10,   0, 0,  0,  0, -63, -63, 0, 0);
        push_beat(  -4,   3,   3, 1,  0,  0, -10,  -7, 0, 0);
        push_beat(  25,   2,   3, 1,  0,  0,  20,  15, 1, 0);
        push_beat(   3,   0,   0, 0,  0,  0,   3,   3, 1, 0);
        push_beat( -64,   0,   0, 0,  0,  1, -63, -48, 0, 3);
    endtask

    // 1-bit block with a change: d = 7.
    task automatic load_b();
        push_beat(  10,   1,   2, 0,  1,  1,   7,   6, 1, 1);
    endtask

    task automatic gap(input int len);
        repeat (len) begin
            @(posedge clk); #1;
            en = 1'b0;
        end
    endtask

    // Drive side info now and the matching Lapo LAT enabled cycles later.
    task automatic play(input int abort_at, input int g1_at, input int g1_len,
                        input int g2_at, input int g2_len, input int drop_idx);
        int   n;
        int   k;
        exp_t e;
        n = sched.size();
        for (int c = 0; c <= n + LAT; c++) begin
            if (c == abort_at) begin
                abase += n;
                sched.delete();
                return;
            end
            if (c == g1_at) gap(g1_len);
            if (c == g2_at) gap(g2_len);
            @(posedge clk); #1;
            en = 1'b1;
            if (c < n) begin
                isval = 1'b1;
                lsys  = 5'(sched[c].lsys);
                lapr  = 7'(sched[c].lapr);
                ihdp  = sched[c].hdp;
                iaddr = 16'(abase + c);
                isop  = sched[c].sop;
                ieop  = sched[c].eop;
            end else begin
                isval = 1'b0; isop = 1'b0; ieop = 1'b0;
            end
            k = c - LAT;
            if (k >= 0 && k < n) begin
                lapo     = 10'(sched[k].lapo);
                lapo_val = (k != drop_idx);
                e.e0 = sched[k].e0; e.e1 = sched[k].e1; e.hd = sched[k].hd;
                e.addr = abase + k; e.sop = sched[k].sop; e.eop = sched[k].eop;
                e.cnt = sched[k].cnt; e.stamp = ecnt;
                exp_q.push_back(e);
            end else begin
                lapo_val = 1'b0;
            end
        end
        abase += n;
        sched.delete();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        chk("drain_pending", exp_q.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_oval"},  oval0,  0);
        chk({tag, "_lextr"}, lextr0, 0);
        chk({tag, "_addr"},  oaddr0, 0);
        chk({tag, "_flags"}, {ohd0, osop0, oeop0, chgv0}, 0);
        chk({tag, "_cnt"},   chgc0,  0);
        chk({tag, "_err"},   oerr0,  0);
        chk({tag, "_oval1"}, oval1,  0);
    endtask

    // Enabled-edge counter for latency checks; en_q marks edges that updated the outputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_q <= 1'b0;
        else        en_q <= en;
        if (rst_n && en) ecnt++;
    end

    // Monitor: pop and compare whenever a fresh output beat is presented.
    always @(negedge clk) begin
        if (en_q && oval0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_oval", 1, 0);
            end else begin
                me = exp_q.pop_front();
                chk("latency",   ecnt - me.stamp, 2);
                chk("lextr_s0",  $signed(lextr0), me.e0);
                chk("lextr_s1",  $signed(lextr1), me.e1);
                chk("oval_s1",   oval1, 1);
                chk("hd",        ohd0, me.hd);
                chk("addr",      oaddr0, me.addr);
                chk("sop",       osop0, me.sop);
                chk("eop",       oeop0, me.eop);
                chk("chg_val",   chgv0, me.eop);
                if (me.eop) chk("chg_cnt", chgc0, me.cnt);
            end
        end else if (en_q) begin
            chk("chg_val_idle", chgv0, 0);
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; isval = 1'b0; ihdp = 1'b0; isop = 1'b0; ieop = 1'b0;
        lapo_val = 1'b0; lsys = '0; lapr = '0; iaddr = '0; lapo = '0;
        #12;
        check_zero_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Arithmetic, saturation, scaling and back-to-back 8-bit + 1-bit blocks.
        load_a();
        load_b();
        play(-1, -1, 0, -1, 0, -1);
        drain();

        // Enable gaps inside the block, one while the delay line is full.
        load_a();
        play(-1, 7, 3, 11, 2, -1);
        drain();
        chk("no_err_gaps", oerr0, 0);

        // Lost Lapo valid on beat 3: beat still processed, error sticks.
        load_a();
        play(-1, -1, 0, -1, 0, 3);
        drain();
        chk("err_set", oerr0, 1);
        repeat (5) @(posedge clk);
        chk("err_sticky", oerr0, 1);

        // Reset mid-block: outputs clear at once, pending beats are discarded.
        load_a();
        play(LAT + 3, -1, 0, -1, 0, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        exp_q.delete();
        en = 1'b0; isval = 1'b0; lapo_val = 1'b0; isop = 1'b0; ieop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Full block after reset is counted from scratch.
        load_a();
        play(-1, -1, 0, -1, 0, -1);
        drain();
        chk("err_after_rst", oerr0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
